// File: rtl/conv_feeder.sv
// rtl/conv_feeder.sv - sequences weights, biases and pixels from layer RAM into one conv instance
module conv_feeder #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            input_dim,
  input  logic [1:0]            window_dim,
  input  logic [ADDR_WIDTH-1:0] weight_base,
  input  logic [ADDR_WIDTH-1:0] bias_base,
  input  logic [ADDR_WIDTH-1:0] pixel_base,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  conv_idle,
  input  logic                  conv_image_done,
  output logic [DATA_WIDTH-1:0] new_pixel_data,
  output logic                  weights_valid,
  output logic                  bias_valid,
  output logic                  new_data_valid,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_B,
    STREAM,
    WAIT_DONE,
    FINISH
  } state_t;

  state_t                state_q, state_d;

  // Job configuration, captured when a job is accepted.
  logic [ADDR_WIDTH-1:0] weight_base_q, weight_base_d;
  logic [ADDR_WIDTH-1:0] bias_base_q, bias_base_d;
  logic [ADDR_WIDTH-1:0] pixel_base_q, pixel_base_d;
  logic [15:0]           coeff_count_q, coeff_count_d;
  logic [15:0]           pix_count_q, pix_count_d;

  // Fetch engine: reads issued and elements transferred in the current phase,
  // one outstanding read, one-entry holding register facing the conv.
  logic [15:0]           issued_q, issued_d;
  logic [15:0]           xfer_q, xfer_d;
  logic                  inflight_q, inflight_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;

  logic                  phase_active;
  logic [15:0]           phase_total;
  logic [ADDR_WIDTH-1:0] phase_base;
  logic                  hold_xfer;
  logic                  last_xfer;
  logic                  rd_issue;

  // Select the element count and base address the fetch engine works against.
  always_comb begin
    phase_active = 1'b0;
    phase_total  = 16'd0;
    phase_base   = '0;
    case (state_q)
      LOAD_W: begin
        phase_active = 1'b1;
        phase_total  = coeff_count_q;
        phase_base   = weight_base_q;
      end
      LOAD_B: begin
        phase_active = 1'b1;
        phase_total  = coeff_count_q;
        phase_base   = bias_base_q;
      end
      STREAM: begin
        phase_active = 1'b1;
        phase_total  = pix_count_q;
        phase_base   = pixel_base_q;
      end
      default: ;
    endcase
  end

  // A transfer happens whenever the presented element meets an idle conv.
  // A new read may go out in the same cycle the holding register drains,
  // which gives one element every two cycles at best.
  assign hold_xfer = phase_active & hold_valid_q & conv_idle;
  assign last_xfer = hold_xfer & (xfer_q == (phase_total - 16'd1));
  assign rd_issue  = phase_active & ~inflight_q & (issued_q < phase_total) &
                     (~hold_valid_q | hold_xfer);

  // Drive memory request and conv-facing outputs from the current state.
  always_comb begin
    mem_rd_en      = rd_issue;
    mem_addr       = '0;
    if (rd_issue) begin
      mem_addr = phase_base + ADDR_WIDTH'(issued_q);
    end
    new_pixel_data = hold_data_q;
    weights_valid  = (state_q == LOAD_W) & hold_valid_q;
    bias_valid     = (state_q == LOAD_B) & hold_valid_q;
    new_data_valid = (state_q == STREAM) & hold_valid_q;
    busy           = (state_q != IDLE);
    done           = (state_q == FINISH);
  end

  // Next-state and fetch-engine update.
  always_comb begin
    state_d       = state_q;
    weight_base_d = weight_base_q;
    bias_base_d   = bias_base_q;
    pixel_base_d  = pixel_base_q;
    coeff_count_d = coeff_count_q;
    pix_count_d   = pix_count_q;
    issued_d      = issued_q;
    xfer_d        = xfer_q;
    inflight_d    = rd_issue;
    hold_valid_d  = hold_valid_q;
    hold_data_d   = hold_data_q;

    if (rd_issue) begin
      issued_d = issued_q + 16'd1;
    end
    if (hold_xfer) begin
      xfer_d       = xfer_q + 16'd1;
      hold_valid_d = 1'b0;
    end
    // Read data lands the cycle after the strobe; the holding register is
    // always empty then because reads only issue into an emptying slot.
    if (inflight_q) begin
      hold_valid_d = 1'b1;
      hold_data_d  = mem_rd_data;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          weight_base_d = weight_base;
          bias_base_d   = bias_base;
          pixel_base_d  = pixel_base;
          coeff_count_d = (window_dim == 2'd3) ? 16'd9 : 16'd1;
          pix_count_d   = {8'd0, input_dim} * {8'd0, input_dim};
          issued_d      = 16'd0;
          xfer_d        = 16'd0;
          state_d       = LOAD_W;
        end
      end
      LOAD_W: begin
        if (last_xfer) begin
          issued_d = 16'd0;
          xfer_d   = 16'd0;
          state_d  = LOAD_B;
        end
      end
      LOAD_B: begin
        if (last_xfer) begin
          issued_d = 16'd0;
          xfer_d   = 16'd0;
          state_d  = (pix_count_q == 16'd0) ? FINISH : STREAM;
        end
      end
      STREAM: begin
        if (last_xfer) begin
          issued_d = 16'd0;
          xfer_d   = 16'd0;
          state_d  = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (conv_image_done) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset aborts any job in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Configuration and fetch-engine registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      weight_base_q <= '0;
      bias_base_q   <= '0;
      pixel_base_q  <= '0;
      coeff_count_q <= 16'd0;
      pix_count_q   <= 16'd0;
      issued_q      <= 16'd0;
      xfer_q        <= 16'd0;
      inflight_q    <= 1'b0;
      hold_valid_q  <= 1'b0;
      hold_data_q   <= '0;
    end else begin
      weight_base_q <= weight_base_d;
      bias_base_q   <= bias_base_d;
      pixel_base_q  <= pixel_base_d;
      coeff_count_q <= coeff_count_d;
      pix_count_q   <= pix_count_d;
      issued_q      <= issued_d;
      xfer_q        <= xfer_d;
      inflight_q    <= inflight_d;
      hold_valid_q  <= hold_valid_d;
      hold_data_q   <= hold_data_d;
    end
  end

endmodule
